// File: rtl/spi_burst_regfile.sv
// SPI burst register file: a header word (RNW + address) followed by a burst
// of data words with optional pointer auto-increment. Holds NUM_RW
// read/write config registers and serves NUM_RO read-only status words.
//
// state | meaning
// IDLE  | chip select high, waiting for a frame
// HDR   | shifting in the RNW + address header
// WDATA | collecting write data words
// RDATA | shifting read words out on serial_out, gapless across words
// HOLD  | frame rejected, ignore serial_in until chip select rises
module spi_burst_regfile #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7,
  parameter int NUM_RW   = 8,
  parameter int RW_BASE  = 1,
  parameter int NUM_RO   = 2,
  parameter int RO_BASE  = 60,
  parameter logic [NUM_RW*DATA_W-1:0] RST_VAL = '0,
  parameter int AUTO_INC = 1
) (
  input  logic                       sclk,
  input  logic                       rstn,
  input  logic                       i_csn,
  input  logic                       i_serial_in,
  output logic                       o_serial_out,
  input  logic [NUM_RO*DATA_W-1:0]   i_status_in,
  output logic [NUM_RW*DATA_W-1:0]   o_cfg_out,
  output logic [NUM_RW-1:0]          o_wr_stb,
  output logic                       o_frame_err,
  output logic                       o_busy
);

  localparam int HDR_W    = ADDR_W + 1;
  localparam int CNT_MAX  = (HDR_W > DATA_W) ? HDR_W : DATA_W;
  localparam int CNT_W    = $clog2(CNT_MAX);
  localparam int ADDR_MAX = 2**ADDR_W - 1;
  localparam int RW_LAST  = RW_BASE + NUM_RW - 1;
  localparam int RO_LAST  = RO_BASE + NUM_RO - 1;

  localparam logic [ADDR_W:0] RW_LO  = (ADDR_W+1)'(RW_BASE);
  localparam logic [ADDR_W:0] RW_END = (ADDR_W+1)'(RW_BASE + NUM_RW);
  localparam logic [ADDR_W:0] RO_LO  = (ADDR_W+1)'(RO_BASE);
  localparam logic [ADDR_W:0] RO_END = (ADDR_W+1)'(RO_BASE + NUM_RO);

  // Reject address maps that overflow the address space or overlap
  if (RW_LAST > ADDR_MAX || RO_LAST > ADDR_MAX) begin : g_range_err
    $error("spi_burst_regfile: register range exceeds address space");
  end
  if (!(RW_LAST < RO_BASE || RO_LAST < RW_BASE)) begin : g_overlap_err
    $error("spi_burst_regfile: RW and RO ranges overlap");
  end

  typedef enum logic [2:0] {IDLE, HDR, WDATA, RDATA, HOLD} state_t;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [ADDR_W-1:0]         r_ptr;
  logic [HDR_W-2:0]          r_hdr;
  logic [DATA_W-1:0]         r_shift;
  logic [NUM_RW*DATA_W-1:0]  r_cfg;
  logic [NUM_RW-1:0]         r_wr_stb;
  logic                      r_serial_out;
  logic                      r_frame_err;
  logic                      r_busy;

  logic [HDR_W-1:0]          w_hdr;
  logic                      w_hdr_rnw;
  logic [ADDR_W-1:0]         w_hdr_addr;
  logic                      w_hdr_last;
  logic                      w_word_last;
  logic [ADDR_W-1:0]         w_ptr_inc;
  logic [ADDR_W-1:0]         w_rd_addr;
  logic                      w_rd_is_rw;
  logic                      w_rd_is_ro;
  logic [ADDR_W-1:0]         w_rd_rw_off;
  logic [ADDR_W-1:0]         w_rd_ro_off;
  logic [DATA_W-1:0]         w_rd_word;
  logic                      w_wr_is_rw;
  logic [ADDR_W-1:0]         w_wr_off;
  logic [DATA_W-1:0]         w_wr_word;

  assign w_hdr       = {r_hdr, i_serial_in};
  assign w_hdr_rnw   = w_hdr[HDR_W-1];
  assign w_hdr_addr  = w_hdr[ADDR_W-1:0];
  assign w_hdr_last  = (r_cnt == CNT_W'(HDR_W-1));
  assign w_word_last = (r_cnt == CNT_W'(DATA_W-1));
  assign w_ptr_inc   = r_ptr + ADDR_W'(AUTO_INC);
  assign w_wr_word   = {r_shift[DATA_W-2:0], i_serial_in};

  // In HDR the read address is the one being decoded; otherwise it is the next burst word
  assign w_rd_addr   = (r_state == HDR) ? w_hdr_addr : w_ptr_inc;
  assign w_rd_is_rw  = ({1'b0, w_rd_addr} >= RW_LO) && ({1'b0, w_rd_addr} < RW_END);
  assign w_rd_is_ro  = ({1'b0, w_rd_addr} >= RO_LO) && ({1'b0, w_rd_addr} < RO_END);
  assign w_rd_rw_off = w_rd_addr - ADDR_W'(RW_BASE);
  assign w_rd_ro_off = w_rd_addr - ADDR_W'(RO_BASE);

  assign w_wr_is_rw  = ({1'b0, r_ptr} >= RW_LO) && ({1'b0, r_ptr} < RW_END);
  assign w_wr_off    = r_ptr - ADDR_W'(RW_BASE);

  // Read word mux; invalid addresses yield zeros
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (w_rd_is_rw && (w_rd_rw_off == ADDR_W'(i))) w_rd_word = r_cfg[i*DATA_W +: DATA_W];
    end
    for (int i = 0; i < NUM_RO; i++) begin
      if (w_rd_is_ro && (w_rd_ro_off == ADDR_W'(i))) w_rd_word = i_status_in[i*DATA_W +: DATA_W];
    end
  end

  // Frame FSM with registered outputs, register writes and write strobes
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_ptr        <= '0;
      r_hdr        <= '0;
      r_shift      <= '0;
      r_cfg        <= RST_VAL;
      r_wr_stb     <= '0;
      r_serial_out <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_wr_stb <= '0;
      if (i_csn) begin
        r_state      <= IDLE;
        r_cnt        <= '0;
        r_ptr        <= '0;
        r_serial_out <= 1'b0;
        r_busy       <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state     <= HDR;
            r_busy      <= 1'b1;
            r_cnt       <= CNT_W'(1);
            r_hdr       <= (HDR_W-1)'(i_serial_in);
            r_frame_err <= 1'b0;
          end
          HDR: begin
            r_hdr <= w_hdr[HDR_W-2:0];
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_hdr_last) begin
              r_cnt <= '0;
              r_ptr <= w_hdr_addr;
              if (w_hdr_rnw && (w_rd_is_rw || w_rd_is_ro)) begin
                r_state      <= RDATA;
                r_serial_out <= w_rd_word[DATA_W-1];
                r_shift      <= {w_rd_word[DATA_W-2:0], 1'b0};
              end else if (!w_hdr_rnw && w_rd_is_rw) begin
                r_state <= WDATA;
              end else begin
                r_state     <= HOLD;
                r_frame_err <= 1'b1;
              end
            end
          end
          WDATA: begin
            r_shift <= w_wr_word;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_word_last) begin
              r_cnt <= '0;
              r_ptr <= w_ptr_inc;
              if (w_wr_is_rw) begin
                for (int i = 0; i < NUM_RW; i++) begin
                  if (w_wr_off == ADDR_W'(i)) begin
                    r_cfg[i*DATA_W +: DATA_W] <= w_wr_word;
                    r_wr_stb[i]               <= 1'b1;
                  end
                end
              end else begin
                r_state     <= HOLD;
                r_frame_err <= 1'b1;
              end
            end
          end
          RDATA: begin
            if (w_word_last) begin
              // Load the next word on the same edge so bursts have no gap
              r_cnt        <= '0;
              r_ptr        <= w_ptr_inc;
              r_serial_out <= w_rd_word[DATA_W-1];
              r_shift      <= {w_rd_word[DATA_W-2:0], 1'b0};
              if (!(w_rd_is_rw || w_rd_is_ro)) r_frame_err <= 1'b1;
            end else begin
              r_cnt        <= r_cnt + CNT_W'(1);
              r_serial_out <= r_shift[DATA_W-1];
              r_shift      <= {r_shift[DATA_W-2:0], 1'b0};
            end
          end
          HOLD: begin
            r_serial_out <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign o_serial_out = r_serial_out;
  assign o_cfg_out    = r_cfg;
  assign o_wr_stb     = r_wr_stb;
  assign o_frame_err  = r_frame_err;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_spi_burst_regfile.sv
// Bench for spi_burst_regfile: frame table plus hand-written abort and reset sequences.
module tb_spi_burst_regfile;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;
  localparam int NUM_RW = 8;
  localparam int NUM_RO = 2;

  logic                      sclk = 1'b0;
  logic                      rstn = 1'b0;
  logic                      csn = 1'b1;
  logic                      serial_in = 1'b0;
  logic [NUM_RO*DATA_W-1:0]  status_in = '0;
  logic                      serial_out;
  logic [NUM_RW*DATA_W-1:0]  cfg_out;
  logic [NUM_RW-1:0]         wr_stb;
  logic                      frame_err;
  logic                      busy;

  spi_burst_regfile #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RW(NUM_RW), .RW_BASE(1),
    .NUM_RO(NUM_RO), .RO_BASE(60), .RST_VAL('0), .AUTO_INC(1)
  ) dut (
    .sclk(sclk), .rstn(rstn), .i_csn(csn), .i_serial_in(serial_in),
    .o_serial_out(serial_out), .i_status_in(status_in), .o_cfg_out(cfg_out),
    .o_wr_stb(wr_stb), .o_frame_err(frame_err), .o_busy(busy)
  );

  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int        idx;
    bit [7:0]  data;
  } wr_t;

  typedef struct {
    bit [7:0]  hdr;
    int        nwords;
    bit [7:0]  wdata [3];
    bit [15:0] status;
    bit [7:0]  rd_exp [3];
    bit        exp_err;
  } frame_t;

  bit [7:0] exp_cfg [NUM_RW];
  bit       exp_so_q [$];
  wr_t      exp_wr_q [$];
  wr_t      mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_cfg();
    logic [63:0] v = '0;
    for (int i = 0; i < NUM_RW; i++) v[i*8 +: 8] = exp_cfg[i];
    return v;
  endfunction

  // Write-strobe scoreboard: every strobe cycle must match a pending expected write
  always @(negedge sclk) begin
    if (rstn === 1'b1 && wr_stb !== '0) begin
      if (exp_wr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wr_stb_unexpected: got %b expected 0 at %0t", wr_stb, $time);
      end else begin
        mon_e = exp_wr_q.pop_front();
        check("wr_stb_onehot", 64'(wr_stb), 64'(8'b1 << mon_e.idx));
        check("wr_data", 64'(cfg_out[mon_e.idx*8 +: 8]), 64'(mon_e.data));
      end
    end
  end

  task automatic run_frame(input frame_t f);
    bit       rnw = f.hdr[7];
    bit [6:0] a;
    bit       valid = 1'b1;
    bit       so_exp;
    status_in = f.status;
    for (int k = 0; k < f.nwords; k++) begin
      if (!rnw) begin
        a = f.hdr[6:0] + 7'(k);
        if (valid && a >= 7'd1 && a <= 7'd8) begin
          exp_wr_q.push_back('{int'(a) - 1, f.wdata[k]});
          exp_cfg[int'(a) - 1] = f.wdata[k];
        end else begin
          valid = 1'b0;
        end
      end
      for (int b = 7; b >= 0; b--) exp_so_q.push_back(rnw ? f.rd_exp[k][b] : 1'b0);
    end
    for (int b = 7; b >= 0; b--) begin
      @(negedge sclk);
      if (b == 6) begin
        check("err_clear_first_bit", 64'(frame_err), 64'(0));
        check("busy_in_frame", 64'(busy), 64'(1));
      end
      csn = 1'b0;
      serial_in = f.hdr[b];
    end
    for (int k = 0; k < f.nwords; k++) begin
      for (int b = 7; b >= 0; b--) begin
        @(negedge sclk);
        so_exp = exp_so_q.pop_front();
        check("serial_out", 64'(serial_out), 64'(so_exp));
        serial_in = rnw ? 1'($urandom) : f.wdata[k][b];
      end
    end
    @(negedge sclk);
    csn = 1'b1;
    @(negedge sclk);
    check("frame_err_end", 64'(frame_err), 64'(f.exp_err));
    check("busy_after_csn", 64'(busy), 64'(0));
    check("cfg_after_frame", 64'(cfg_out), model_cfg());
    check("wr_queue_drained", 64'(exp_wr_q.size()), 64'(0));
  endtask

  frame_t tbl [10];
  frame_t fx;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'h03, 1, '{8'hA5, 8'h00, 8'h00}, 16'h0000, '{8'h00, 8'h00, 8'h00}, 1'b0};
    tbl[1] = '{8'h07, 3, '{8'h11, 8'h22, 8'h33}, 16'h0000, '{8'h00, 8'h00, 8'h00}, 1'b1};
    tbl[2] = '{8'hBC, 3, '{8'h00, 8'h00, 8'h00}, 16'h5A3C, '{8'h3C, 8'h5A, 8'h00}, 1'b1};
    tbl[3] = '{8'h3C, 1, '{8'h77, 8'h00, 8'h00}, 16'h5A3C, '{8'h00, 8'h00, 8'h00}, 1'b1};
    tbl[4] = '{8'h83, 2, '{8'h00, 8'h00, 8'h00}, 16'h0000, '{8'hA5, 8'h00, 8'h00}, 1'b0};
    tbl[5] = '{8'h01, 2, '{8'hC3, 8'h96, 8'h00}, 16'h0000, '{8'h00, 8'h00, 8'h00}, 1'b0};
    tbl[6] = '{8'h87, 3, '{8'h00, 8'h00, 8'h00}, 16'h0000, '{8'h11, 8'h22, 8'h00}, 1'b1};
    tbl[7] = '{8'h81, 2, '{8'h00, 8'h00, 8'h00}, 16'h0000, '{8'hC3, 8'h96, 8'h00}, 1'b0};
    tbl[8] = '{8'hC0, 1, '{8'h00, 8'h00, 8'h00}, 16'h0000, '{8'h00, 8'h00, 8'h00}, 1'b1};
    tbl[9] = '{8'hBD, 2, '{8'h00, 8'h00, 8'h00}, 16'hC35A, '{8'hC3, 8'h00, 8'h00}, 1'b1};
    for (int i = 0; i < NUM_RW; i++) exp_cfg[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge sclk);
    check("rst_cfg", 64'(cfg_out), 64'(0));
    check("rst_wr_stb", 64'(wr_stb), 64'(0));
    check("rst_serial_out", 64'(serial_out), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_frame_err", 64'(frame_err), 64'(0));
    rstn = 1'b1;
    @(negedge sclk);

    for (int i = 0; i < 10; i++) run_frame(tbl[i]);

    // Abort a write to addr 1 after 5 data bits: no write, no strobe
    for (int b = 7; b >= 0; b--) begin
      @(negedge sclk);
      csn = 1'b0;
      serial_in = (b == 0);
    end
    for (int b = 0; b < 5; b++) begin
      @(negedge sclk);
      serial_in = 1'b1;
    end
    @(negedge sclk);
    csn = 1'b1;
    @(negedge sclk);
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_wr_stb", 64'(wr_stb), 64'(0));
    check("abort_cfg", 64'(cfg_out), model_cfg());

    // Counters must start clean after an abort
    fx = '{8'h02, 1, '{8'h3E, 8'h00, 8'h00}, 16'h0000, '{8'h00, 8'h00, 8'h00}, 1'b0};
    run_frame(fx);

    // Reset mid-burst while the first word's strobe is high
    exp_wr_q.push_back('{0, 8'h44});
    exp_cfg[0] = 8'h44;
    for (int b = 7; b >= 0; b--) begin
      @(negedge sclk);
      csn = 1'b0;
      serial_in = (b == 0);
    end
    for (int b = 7; b >= 0; b--) begin
      @(negedge sclk);
      serial_in = 8'h44 >> b;
    end
    @(negedge sclk);
    serial_in = 1'b1;
    #2 rstn = 1'b0;
    #1;
    check("midrst_cfg", 64'(cfg_out), 64'(0));
    check("midrst_wr_stb", 64'(wr_stb), 64'(0));
    check("midrst_serial_out", 64'(serial_out), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_frame_err", 64'(frame_err), 64'(0));
    check("midrst_wr_queue", 64'(exp_wr_q.size()), 64'(0));
    for (int i = 0; i < NUM_RW; i++) exp_cfg[i] = 8'h00;
    exp_so_q.delete();
    exp_wr_q.delete();
    csn = 1'b1;
    repeat (2) @(negedge sclk);
    rstn = 1'b1;
    @(negedge sclk);

    fx = '{8'h05, 1, '{8'h5E, 8'h00, 8'h00}, 16'h0000, '{8'h00, 8'h00, 8'h00}, 1'b0};
    run_frame(fx);
    fx = '{8'h85, 2, '{8'h00, 8'h00, 8'h00}, 16'h0000, '{8'h5E, 8'h00, 8'h00}, 1'b0};
    run_frame(fx);

    check("serial_queue_drained", 64'(exp_so_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
